exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception/interrupt sequencer for the single-cycle MIPS core. It captures the four exception sources (syscall, invalid opcode, overflow, external interrupt) into sticky pending bits and selects one by fixed priority. It then redirects the PC to the handler vector, saves the return address, and returns on RFE with a one-cycle clear pulse to the serviced source. It sits between the datapath's PC-next logic and the controller, and owns the EPC and cause registers.

## Interface
Parameters:
- HANDLER_VEC, 32'h0000_0100: word-aligned handler entry address loaded into the PC on exception entry.
- RESET_MASK, 4'b1111: reset value of the enable mask (1 = source enabled).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on a rising edge where it is 1.
- irq  in  4  request pulses or levels. Bit 0 = syscall, bit 1 = invalid, bit 2 = overflow, bit 3 = ext_int.
- mask_we  in  1  write enable for the mask register.
- mask_d  in  4  new mask value.
- rfe  in  1  the current instruction is RFE, as decoded by the controller.
- pc  in  32  address of the instruction executing this cycle.
- pc_sel  out  2  PC-next mux select. 0 = normal datapath next-PC, 1 = HANDLER_VEC, 2 = epc. 3 is unused.
- kill  out  1  suppresses regwrite, memwrite and multien for the current instruction.
- epc  out  32  saved return address.
- cause  out  2  ID of the source being serviced (0..3).
- busy  out  1  handler in progress (state ENTER or HANDLER).
- ack  out  4  one-hot clear pulse to the serviced source, high for one cycle.
- pending  out  4  sticky pending bits, for status and debug.

## Operation
- Pending capture: `pending[i]` is set at any edge where `irq[i]` = 1.
  - It is cleared only at the edge where `ack[i]` = 1.
  - If set and clear coincide, set wins and the bit stays 1.
  - Masked sources still capture but are not taken.
- Selection: `eligible = pending & mask`. The lowest index wins: syscall > invalid > overflow > ext_int.
- Mask register: loaded from `mask_d` at an edge where `mask_we` = 1. The write is honoured in every state.
- States:
  - IDLE: `pc_sel` = 0, `kill` = 0.
    - If `eligible` is nonzero, go to ENTER at the next edge.
    - In the same edge, latch `cause` = ID of the winning source.
    - `rfe` is ignored in IDLE.
  - ENTER (exactly one cycle): `pc_sel` = 1 and `kill` = 1.
    - The instruction at `pc` does not commit and re-executes after return.
    - At the edge: `epc` <= `pc`; go to HANDLER.
  - HANDLER: `pc_sel` = 0, `kill` = 0, and the handler runs normally.
    - Nesting is not supported: new requests only accumulate in `pending`.
    - `cause` and `epc` are frozen.
    - If `rfe` = 1 in a cycle, that same cycle drives `pc_sel` = 2, `kill` = 0 and `ack` = one-hot(`cause`). Go to IDLE at the edge.
    - At that edge, `pending[cause]` clears unless that source is re-asserted in the same cycle.
- Back-to-back: a source still eligible on return to IDLE is taken normally. There are no idle bubbles other than the single IDLE cycle.
- Mask changes in HANDLER do not affect the current service.
- Reset, in any state:
  - state = IDLE
  - `pending` = 0, `epc` = 0, `cause` = 0
  - `mask` = RESET_MASK
  - outputs `pc_sel` = 0, `kill` = 0, `ack` = 0, `busy` = 0.
  - A handler interrupted by reset is abandoned and no `ack` is issued.

## Timing
- `irq` sampled at edge N leads to:
  - `pending` set after edge N;
  - ENTER during cycle N+1 to N+2;
  - PC = HANDLER_VEC after edge N+2.
  - Entry latency is therefore 2 edges.
- `epc` becomes valid after the ENTER edge and is stable throughout HANDLER.
- `rfe` to PC = `epc`: next edge, with no extra cycle.
- `pc_sel`, `kill`, `ack` and `busy` are combinational from state, `cause` and `rfe`. There is no path from `irq` to outputs.
- `busy` is 1 in ENTER and HANDLER.
- `pending` and `epc` outputs are registered.

## Test plan
- Single syscall:
  - Stimulus: `irq` = 0001 for 1 cycle while `pc` = 0x40.
  - ENTER begins 1 cycle later, with `pc_sel` = 1 and `kill` = 1.
  - Then `epc` = 0x40, `cause` = 0.
  - `rfe` in HANDLER gives `pc_sel` = 2 and `ack` = 0001 that cycle, and `pending` = 0 after the edge.
- Priority and back-to-back:
  - Stimulus: `irq` = 1100 in the same cycle.
  - `cause` = 2 is serviced first and `ack` = 0100.
  - After 1 IDLE cycle, ENTER again with `cause` = 3 and `ack` = 1000 on the second `rfe`.
- Masking:
  - Stimulus: `mask` = 1110, then `irq` = 0001.
  - Result: `pending` = 0001, no ENTER, `busy` = 0.
  - Then write `mask` = 1111: ENTER follows 1 cycle after the mask-write edge.
- Set/clear collision and no nesting:
  - Stimulus: `irq` = 0010 during HANDLER, with `cause` = 1, in the same cycle as `rfe`.
  - `pending[1]` stays 1 and the sequencer re-enters with `cause` = 1.
  - An `irq` = 0001 arriving mid-HANDLER does not change `pc_sel` until the next IDLE.
- Reset mid-handler:
  - Stimulus: assert `reset` for 1 cycle in HANDLER, with `epc` = 0x80.
  - After the edge: `epc` = 0, `pending` = 0, `busy` = 0, `mask` = 1111, and `ack` never pulses.
- `rfe` in IDLE: no state change and `pc_sel` stays 0.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer
//   Exception/interrupt sequencer for the single-cycle MIPS core. Captures the
//   four exception sources into sticky pending bits, picks one by fixed
//   priority, steers the PC to the handler, saves the return address and
//   returns on RFE with a one-cycle clear pulse to the serviced source.
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   reset    in   synchronous active-high reset
//   irq      in   [0]=syscall [1]=invalid [2]=overflow [3]=ext_int
//   mask_we  in   mask register write enable
//   mask_d   in   new mask value (1 = source enabled)
//   rfe      in   current instruction is RFE
//   pc       in   address of the instruction executing this cycle
//   pc_sel   out  0 = datapath next-PC, 1 = HANDLER_VEC, 2 = epc
//   kill     out  suppress regwrite/memwrite/multien this cycle
//   epc      out  saved return address
//   cause    out  ID of the source being serviced
//   busy     out  handler in progress (ENTER or HANDLER)
//   ack      out  one-hot clear pulse to the serviced source
//   pending  out  sticky pending bits
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | normal execution, waiting for an eligible source
// S_ENTER  | one cycle: kill current instr, redirect to handler, save pc
// S_HANDLER| handler running; leaves on rfe with an ack to the source

module exc_sequencer #(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0100,
  parameter logic [3:0]  RESET_MASK  = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq,
  input  logic        mask_we,
  input  logic [3:0]  mask_d,
  input  logic        rfe,
  input  logic [31:0] pc,
  output logic [1:0]  pc_sel,
  output logic        kill,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        busy,
  output logic [3:0]  ack,
  output logic [3:0]  pending
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTER   = 2'd1,
    S_HANDLER = 2'd2
  } state_e;

  localparam logic [1:0] SEL_NEXT = 2'd0;
  localparam logic [1:0] SEL_VEC  = 2'd1;
  localparam logic [1:0] SEL_EPC  = 2'd2;

  state_e      state_q;
  logic [3:0]  mask_q;
  logic [3:0]  pending_q;
  logic [3:0]  pending_d;
  logic [31:0] epc_q;
  logic [1:0]  cause_q;

  logic [3:0]  eligible;
  logic        any_eligible;
  logic [1:0]  winner_id;
  logic        returning;
  logic [3:0]  ack_w;

  // The handler address itself is applied by the PC-next mux when
  // pc_sel selects it; the sequencer only drives the select.
  logic [31:0] unused_handler_vec;
  assign unused_handler_vec = HANDLER_VEC;

  // Fixed priority: lowest index wins.
  always_comb begin
    eligible     = pending_q & mask_q;
    any_eligible = |eligible;
    winner_id    = 2'd0;
    if (eligible[0])      winner_id = 2'd0;
    else if (eligible[1]) winner_id = 2'd1;
    else if (eligible[2]) winner_id = 2'd2;
    else if (eligible[3]) winner_id = 2'd3;
  end

  // Reset gates the decoded outputs so a handler cut short by reset never
  // acks its source, even if rfe happens to be high in that cycle.
  assign returning = (state_q == S_HANDLER) && rfe && !reset;
  assign ack_w     = returning ? (4'b0001 << cause_q) : 4'b0000;

  // Clear first, then set: a source re-asserted in the ack cycle stays pending.
  assign pending_d = (pending_q & ~ack_w) | irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= RESET_MASK;
      pending_q <= 4'b0000;
      epc_q     <= 32'h0000_0000;
      cause_q   <= 2'd0;
    end else begin
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_d;
      end
      case (state_q)
        S_IDLE: begin
          if (any_eligible) begin
            cause_q <= winner_id;
            state_q <= S_ENTER;
          end
        end
        S_ENTER: begin
          epc_q   <= pc;
          state_q <= S_HANDLER;
        end
        S_HANDLER: begin
          if (rfe) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pc_sel = SEL_NEXT;
    kill   = 1'b0;
    busy   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_ENTER: begin
          pc_sel = SEL_VEC;
          kill   = 1'b1;
          busy   = 1'b1;
        end
        S_HANDLER: begin
          busy = 1'b1;
          if (rfe) begin
            pc_sel = SEL_EPC;
          end
        end
        default: begin
          pc_sel = SEL_NEXT;
        end
      endcase
    end
  end

  assign ack     = ack_w;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencer.

module tb_exc_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_d;
  logic        rfe;
  logic [31:0] pc;
  logic [1:0]  pc_sel;
  logic        kill;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        busy;
  logic [3:0]  ack;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  exc_sequencer #(
    .HANDLER_VEC (32'h0000_0100),
    .RESET_MASK  (4'b1111)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .rfe     (rfe),
    .pc      (pc),
    .pc_sel  (pc_sel),
    .kill    (kill),
    .epc     (epc),
    .cause   (cause),
    .busy    (busy),
    .ack     (ack),
    .pending (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the sequencer is doing, in plain terms.
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;
  logic [31:0] m_epc;
  int          m_cause;
  bit          m_entering;
  bit          m_in_handler;
  logic [3:0]  m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend       = 4'b0000;
    m_mask       = 4'b1111;
    m_epc        = 32'h0;
    m_cause      = 0;
    m_entering   = 1'b0;
    m_in_handler = 1'b0;
    m_ack        = 4'b0000;
  endtask

  // Drive one cycle's inputs and compare every output with the model.
  task automatic dr(input logic [3:0] i_irq, input logic i_rfe, input logic i_mwe,
                    input logic [3:0] i_md, input logic [31:0] i_pc, input logic i_rst);
    logic [1:0] e_sel;
    @(negedge clk);
    irq     = i_irq;
    rfe     = i_rfe;
    mask_we = i_mwe;
    mask_d  = i_md;
    pc      = i_pc;
    reset   = i_rst;
    #1;
    e_sel = 2'd0;
    m_ack = 4'b0000;
    if (!i_rst) begin
      if (m_entering) e_sel = 2'd1;
      else if (m_in_handler && i_rfe) begin
        e_sel = 2'd2;
        m_ack[m_cause] = 1'b1;
      end
    end
    chk("pc_sel",  {30'd0, pc_sel}, {30'd0, e_sel});
    chk("kill",    {31'd0, kill}, {31'd0, (!i_rst && m_entering)});
    chk("busy",    {31'd0, busy}, {31'd0, (!i_rst && (m_entering || m_in_handler))});
    chk("ack",     {28'd0, ack}, {28'd0, m_ack});
    chk("epc",     epc, m_epc);
    chk("cause",   {30'd0, cause}, m_cause);
    chk("pending", {28'd0, pending}, {28'd0, m_pend});
  endtask

  // Clock edge: advance the model with the inputs driven this cycle.
  task automatic tk();
    logic [3:0] elig;
    int         win;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      elig = m_pend & m_mask;
      win  = -1;
      for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
      if (m_entering) begin
        m_epc        = pc;
        m_entering   = 1'b0;
        m_in_handler = 1'b1;
      end else if (m_in_handler) begin
        if (rfe) m_in_handler = 1'b0;
      end else if (win >= 0) begin
        m_entering = 1'b1;
        m_cause    = win;
      end
      m_pend = (m_pend & ~m_ack) | irq;
      if (mask_we) m_mask = mask_d;
    end
  endtask

  task automatic cyc(input logic [3:0] i_irq, input logic i_rfe, input logic i_mwe,
                     input logic [3:0] i_md, input logic [31:0] i_pc, input logic i_rst);
    dr(i_irq, i_rfe, i_mwe, i_md, i_pc, i_rst);
    tk();
  endtask

  initial begin
    reset = 1'b1; irq = 4'b0; mask_we = 1'b0; mask_d = 4'b0; rfe = 1'b0; pc = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    dr(0, 0, 0, 0, 32'h0, 0);
    chk("rst_pending", {28'd0, pending}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    tk();

    // Single syscall at pc 0x40
    cyc(4'b0001, 0, 0, 0, 32'h40, 0);
    cyc(0, 0, 0, 0, 32'h40, 0);
    dr(0, 0, 0, 0, 32'h40, 0);
    chk("sys_enter_sel", {30'd0, pc_sel}, 32'd1);
    chk("sys_enter_kill", {31'd0, kill}, 32'd1);
    tk();
    dr(0, 0, 0, 0, 32'h100, 0);
    chk("sys_epc", epc, 32'h40);
    chk("sys_cause", {30'd0, cause}, 32'd0);
    tk();
    dr(0, 1, 0, 0, 32'h104, 0);
    chk("sys_rfe_sel", {30'd0, pc_sel}, 32'd2);
    chk("sys_ack", {28'd0, ack}, 32'h1);
    tk();
    dr(0, 0, 0, 0, 32'h40, 0);
    chk("sys_pend_clr", {28'd0, pending}, 32'h0);
    tk();

    // Priority and back-to-back: overflow before ext_int
    cyc(4'b1100, 0, 0, 0, 32'h200, 0);
    cyc(0, 0, 0, 0, 32'h200, 0);
    cyc(0, 0, 0, 0, 32'h200, 0);
    dr(0, 0, 0, 0, 32'h100, 0);
    chk("pri_cause2", {30'd0, cause}, 32'd2);
    tk();
    dr(0, 1, 0, 0, 32'h104, 0);
    chk("pri_ack2", {28'd0, ack}, 32'h4);
    tk();
    dr(0, 0, 0, 0, 32'h200, 0);
    chk("pri_idle_busy", {31'd0, busy}, 32'd0);
    chk("pri_left", {28'd0, pending}, 32'h8);
    tk();
    dr(0, 0, 0, 0, 32'h200, 0);
    chk("pri_reenter", {30'd0, pc_sel}, 32'd1);
    tk();
    dr(0, 0, 0, 0, 32'h100, 0);
    chk("pri_cause3", {30'd0, cause}, 32'd3);
    tk();
    dr(0, 1, 0, 0, 32'h104, 0);
    chk("pri_ack3", {28'd0, ack}, 32'h8);
    tk();
    cyc(0, 0, 0, 0, 32'h200, 0);

    // Masking: syscall disabled captures but is not taken
    cyc(0, 0, 1, 4'b1110, 32'h300, 0);
    cyc(4'b0001, 0, 0, 0, 32'h300, 0);
    dr(0, 0, 0, 0, 32'h304, 0);
    chk("msk_pending", {28'd0, pending}, 32'h1);
    tk();
    dr(0, 0, 0, 0, 32'h308, 0);
    chk("msk_not_busy", {31'd0, busy}, 32'd0);
    tk();
    cyc(0, 0, 1, 4'b1111, 32'h30c, 0);
    dr(0, 0, 0, 0, 32'h310, 0);
    chk("msk_idle_cycle", {30'd0, pc_sel}, 32'd0);
    tk();
    dr(0, 0, 0, 0, 32'h314, 0);
    chk("msk_enter", {30'd0, pc_sel}, 32'd1);
    tk();
    cyc(0, 0, 0, 0, 32'h100, 0);
    cyc(0, 1, 0, 0, 32'h104, 0);
    cyc(0, 0, 0, 0, 32'h314, 0);

    // Set/clear collision on invalid opcode, then no nesting
    cyc(4'b0010, 0, 0, 0, 32'h400, 0);
    cyc(0, 0, 0, 0, 32'h400, 0);
    cyc(0, 0, 0, 0, 32'h400, 0);
    dr(4'b0010, 1, 0, 0, 32'h104, 0);
    chk("col_ack", {28'd0, ack}, 32'h2);
    tk();
    dr(0, 0, 0, 0, 32'h400, 0);
    chk("col_pend_kept", {28'd0, pending}, 32'h2);
    tk();
    cyc(0, 0, 0, 0, 32'h400, 0);
    dr(4'b0001, 0, 0, 0, 32'h100, 0);
    chk("col_recause", {30'd0, cause}, 32'd1);
    tk();
    dr(0, 0, 0, 0, 32'h104, 0);
    chk("nest_sel", {30'd0, pc_sel}, 32'd0);
    chk("nest_cause", {30'd0, cause}, 32'd1);
    tk();
    cyc(0, 1, 0, 0, 32'h108, 0);
    cyc(0, 0, 0, 0, 32'h400, 0);
    dr(0, 0, 0, 0, 32'h400, 0);
    chk("nest_later", {30'd0, pc_sel}, 32'd1);
    tk();
    cyc(0, 0, 0, 0, 32'h100, 0);
    cyc(0, 1, 0, 0, 32'h104, 0);
    cyc(0, 0, 0, 0, 32'h400, 0);

    // Reset mid-handler with epc 0x80, rfe coinciding with reset
    cyc(4'b0100, 0, 0, 0, 32'h80, 0);
    cyc(0, 0, 0, 0, 32'h80, 0);
    cyc(0, 0, 0, 0, 32'h80, 0);
    dr(4'b0001, 0, 1, 4'b0000, 32'h100, 0);
    chk("rstm_epc", epc, 32'h80);
    tk();
    dr(0, 1, 0, 0, 32'h104, 1);
    chk("rstm_no_ack", {28'd0, ack}, 32'h0);
    tk();
    dr(0, 0, 0, 0, 32'h0, 0);
    chk("rstm_epc0", epc, 32'h0);
    chk("rstm_pend0", {28'd0, pending}, 32'h0);
    chk("rstm_busy0", {31'd0, busy}, 32'd0);
    tk();
    cyc(4'b1000, 0, 0, 0, 32'h4, 0);
    cyc(0, 0, 0, 0, 32'h8, 0);
    dr(0, 0, 0, 0, 32'h8, 0);
    chk("rstm_mask_back", {31'd0, busy}, 32'd1);
    tk();
    cyc(0, 0, 0, 0, 32'h100, 0);
    cyc(0, 1, 0, 0, 32'h104, 0);

    // rfe in IDLE does nothing
    dr(0, 1, 0, 0, 32'h500, 0);
    chk("idle_rfe_sel", {30'd0, pc_sel}, 32'd0);
    tk();
    dr(0, 0, 0, 0, 32'h504, 0);
    chk("idle_rfe_busy", {31'd0, busy}, 32'd0);
    tk();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  r_irq;
      logic        r_rfe;
      logic        r_mwe;
      logic [3:0]  r_md;
      logic        r_rst;
      r_irq = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      r_rfe = m_in_handler ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      r_mwe = ($urandom_range(0, 19) == 0);
      r_md  = 4'($urandom_range(0, 15));
      r_rst = ($urandom_range(0, 299) == 0);
      cyc(r_irq, r_rfe, r_mwe, r_md, $urandom & 32'hFFFF_FFFC, r_rst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
